// File: rtl/mul_pkg.sv
// Shared types and defaults for the sequential shift-add multiplier.
package mul_pkg;

  localparam int unsigned MUL_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mul_seq_if.sv
// Bundle of the multiplier's start/result signals, for whoever drives or observes the block.
interface mul_seq_if
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH_DEFAULT
);

  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               enable;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output a,
    output b,
    output enable,
    input  busy,
    input  done,
    input  product
  );

  modport slave (
    input  a,
    input  b,
    input  enable,
    output busy,
    output done,
    output product
  );

endinterface

// File: rtl/mul_seq.sv
// Radix-2 shift-add unsigned multiplier: WIDTH iterations per product, fixed latency,
// back-to-back starts accepted from the DONE cycle.
module mul_seq
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH_DEFAULT
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               enable,
  output logic               busy,
  output logic [2*WIDTH-1:0] product,
  output logic               done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  mul_state_e         state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH:0]     hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH:0]     sum;

  // hi carries one extra bit so the add never loses its carry before the shift.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    sum       = hi_q + ({(WIDTH + 1){lo_q[0]}} & {1'b0, a_q});

    case (state_q)
      IDLE, DONE: begin
        if (enable) begin
          a_d     = a;
          hi_d    = '0;
          lo_d    = b;
          cnt_d   = '0;
          state_d = CALC;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        hi_d  = {1'b0, sum[WIDTH:1]};
        lo_d  = {sum[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d   = DONE;
          done_d    = 1'b1;
          product_d = {hi_d[WIDTH-1:0], lo_d};
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq: directed operands, expected products queued at issue time
// and popped by an independent monitor whenever done is seen.
module tb_mul_seq;
  import mul_pkg::*;

  localparam int unsigned WIDTH = 32;

  typedef struct {
    logic [2*WIDTH-1:0] product;
    int                 accept_edge;
  } exp_t;

  logic sys_clk;
  logic sys_rst_n;
  int   edge_cnt;
  int   vectors;
  int   miscompares;
  exp_t sb[$];

  mul_seq_if #(.WIDTH(WIDTH)) bus ();

  mul_seq #(.WIDTH(WIDTH)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .a         (bus.a),
    .b         (bus.b),
    .enable    (bus.enable),
    .busy      (bus.busy),
    .product   (bus.product),
    .done      (bus.done)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial edge_cnt = 0;
  always @(posedge sys_clk) edge_cnt <= edge_cnt + 1;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
    end
  endtask

  // Counting the acceptance edge as the first, done must appear on edge WIDTH+1.
  always @(negedge sys_clk) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        check_output("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_output("product", bus.product, e.product);
        check_output("latency", 64'(edge_cnt - e.accept_edge), 64'(WIDTH));
      end
    end
  end

  // Called at a negedge; the next rising edge is the acceptance edge.
  task automatic apply_stimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                input int hold, input bit expect_result);
    bus.a      = av;
    bus.b      = bv;
    bus.enable = 1'b1;
    if (expect_result)
      sb.push_back('{product: 64'(av) * 64'(bv), accept_edge: edge_cnt + 1});
    repeat (hold) @(negedge sys_clk);
    bus.enable = 1'b0;
  endtask

  task automatic wait_for_done(input string name);
    int n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    check_output(name, 64'(bus.done), 64'd1);
  endtask

  initial begin
    int  n;
    bit  bad;
    vectors     = 0;
    miscompares = 0;
    sys_rst_n   = 1'b0;
    bus.a       = '0;
    bus.b       = '0;
    bus.enable  = 1'b0;

    #23;
    check_output("reset_busy", 64'(bus.busy), 64'd0);
    check_output("reset_done", 64'(bus.done), 64'd0);
    check_output("reset_product", bus.product, 64'd0);

    // Basic 3*5, started on the very first edge after reset release.
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    apply_stimulus(32'd3, 32'd5, 1, 1'b1);
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      n++;
      @(negedge sys_clk);
    end
    check_output("busy_cycles", 64'(n), 64'd32);
    check_output("done_after_busy", 64'(bus.done), 64'd1);
    @(negedge sys_clk);
    check_output("done_single_pulse", 64'(bus.done), 64'd0);
    check_output("product_hold_idle", bus.product, 64'h0000_0000_0000_000F);

    // Maximum operands exercise the carry bit of the accumulator.
    apply_stimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b1);
    wait_for_done("max_done");
    @(negedge sys_clk);
    check_output("max_product_hold", bus.product, 64'hFFFF_FFFE_0000_0001);

    // Zero multiplicand.
    apply_stimulus(32'd0, 32'h1234_5678, 1, 1'b1);
    wait_for_done("zero_done");
    @(negedge sys_clk);

    // Enable held through most of CALC must not restart the operation.
    apply_stimulus(32'd9, 32'd11, 30, 1'b1);
    wait_for_done("hold_done");
    bad = 1'b0;
    repeat (40) begin
      @(negedge sys_clk);
      if (bus.busy !== 1'b0) bad = 1'b1;
    end
    check_output("hold_no_restart", 64'(bad), 64'd0);

    // Back-to-back: 3*5, then 7*6 issued during the DONE cycle.
    apply_stimulus(32'd3, 32'd5, 1, 1'b1);
    wait_for_done("b2b_first_done");
    check_output("b2b_first_product", bus.product, 64'd15);
    bus.a      = 32'd7;
    bus.b      = 32'd6;
    bus.enable = 1'b1;
    sb.push_back('{product: 64'd42, accept_edge: edge_cnt + 1});
    @(negedge sys_clk);
    bus.enable = 1'b0;
    n   = 1;
    bad = 1'b0;
    while (bus.done !== 1'b1 && n < 100) begin
      if (bus.product !== 64'd15) bad = 1'b1;
      @(negedge sys_clk);
      n++;
    end
    check_output("b2b_gap", 64'(n), 64'd33);
    check_output("b2b_first_held", 64'(bad), 64'd0);
    @(negedge sys_clk);

    // Reset during iteration 10 aborts with no result.
    apply_stimulus(32'd100, 32'd200, 1, 1'b0);
    repeat (9) @(negedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check_output("abort_busy", 64'(bus.busy), 64'd0);
    check_output("abort_done", 64'(bus.done), 64'd0);
    check_output("abort_product", bus.product, 64'd0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    bad = 1'b0;
    repeat (40) begin
      @(negedge sys_clk);
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) bad = 1'b1;
    end
    check_output("abort_stays_idle", 64'(bad), 64'd0);

    // Operands scrambled every cycle after acceptance.
    apply_stimulus(32'h10, 32'h10, 1, 1'b1);
    for (int i = 0; i < 32; i++) begin
      bus.a = 32'hA5A5_0000 + 32'(i);
      bus.b = ~bus.a;
      @(negedge sys_clk);
    end
    wait_for_done("scramble_done");
    check_output("scramble_product", bus.product, 64'h100);
    repeat (5) @(negedge sys_clk);
    check_output("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
